// File: rtl/apb_master_bridge.sv
// APB initiator bridging a valid/ready command stream to APB transfers.
// Single outstanding transfer, registered APB outputs, ACCESS-phase timeout
// with a saturating error counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready_o high
// SETUP  | APB setup phase, psel_o=1, penable_o=0, exactly one cycle
// ACCESS | APB access phase, waiting for pready_i or the timeout
// RESP   | response held on rsp_* until rsp_ready_i
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic [7:0]                error_count_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(0);

  logic [1:0]       state;
  logic [CNT_W-1:0] timeout_cnt;
  logic             timeout_hit;

  // Command acceptance is purely a function of state.
  always_comb begin
    cmd_ready_o = (state == S_IDLE);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_cnt == CNT_LAST);
  end

  // Transfer sequencing, APB output registers and response capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= S_IDLE;
      timeout_cnt   <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_error_o   <= 1'b0;
      error_count_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            pwrite_o <= cmd_write_i;
            paddr_o  <= cmd_addr_i;
            pwdata_o <= cmd_wdata_i;
            psel_o   <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_o   <= 1'b1;
          timeout_cnt <= '0;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready_i takes priority over a timeout firing the same cycle.
          if (pready_i) begin
            rsp_rdata_o <= pwrite_o ? 32'h0 : prdata_i;
            rsp_error_o <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata_o <= 32'h0;
            rsp_error_o <= 1'b1;
            if (error_count_o != 8'hFF) begin
              error_count_o <= error_count_o + 8'd1;
            end
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          psel_o      <= 1'b0;
          penable_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed, table-driven bench for apb_master_bridge with a behavioural
// APB slave that inserts a chosen number of wait states.
module tb_apb_master_bridge;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [15:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic [7:0]  error_count_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [15:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .error_count_o(error_count_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_acc;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one command and complete its handshake; returns just after the
  // handshake edge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready_o) chk("cmd_ready_wait", {31'h0, cmd_ready_o}, 32'h1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Acts as the APB slave from the first sample after the command handshake,
  // then consumes the response (optionally stalling rsp_ready_i while a
  // further command is pending).
  task automatic finish_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd, input int stall,
                             output int lat, output int acc, output int psel_n,
                             output int pen_n, output logic [31:0] rdata,
                             output logic err, output int bad);
    lat = 1; acc = 0; psel_n = 0; pen_n = 0; bad = 0;
    rdata = '0; err = 1'b0;
    while (!rsp_valid_o && lat < 200) begin
      if (psel_o) psel_n++;
      if (penable_o) pen_n++;
      if (penable_o && !psel_o) bad++;
      if (psel_o && (paddr_o !== addr || pwrite_o !== wr || (wr && pwdata_o !== wd))) bad++;
      if (psel_o && penable_o) acc++;
      pready_i = psel_o && penable_o && (acc == waits + 1);
      prdata_i = rd;
      step();
      lat++;
    end
    pready_i = 1'b0;
    if (!rsp_valid_o) begin
      chk("rsp_valid_timeout", {31'h0, rsp_valid_o}, 32'h1);
    end else begin
      if (psel_o || penable_o) bad++;
      rdata = rsp_rdata_o;
      err   = rsp_error_o;
      if (stall > 0) begin
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 16'h0044;
        cmd_wdata_i = 32'h0000_0055;
        for (int i = 0; i < stall; i++) begin
          if (cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 ||
              rsp_rdata_o !== rdata || rsp_error_o !== err || psel_o) bad++;
          step();
        end
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      if (rsp_valid_o) bad++;
    end
  endtask

  initial begin : main
    int lat, acc, psel_n, pen_n, bad;
    logic [31:0] rdata;
    logic err;

    //          wr    addr      wd            waits rd            exp_rdata     err  lat acc cnt
    vecs[0] = '{1'b1, 16'h0000, 32'h0000_0011,  0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0,  3,  1, 8'd0};
    vecs[1] = '{1'b0, 16'h000C, 32'h0000_0000,  1, 32'h0000_0400, 32'h0000_0400, 1'b0,  4,  2, 8'd0};
    vecs[2] = '{1'b0, 16'h1234, 32'h0000_0000,  0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0,  3,  1, 8'd0};
    vecs[3] = '{1'b1, 16'hFFFC, 32'hCAFE_BABE,  3, 32'h1111_2222, 32'h0000_0000, 1'b0,  6,  4, 8'd0};
    vecs[4] = '{1'b0, 16'h0008, 32'h0000_0000, 15, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 18, 16, 8'd0};
    vecs[5] = '{1'b0, 16'h0010, 32'h0000_0000, 99, 32'h7777_7777, 32'h0000_0000, 1'b1, 18, 16, 8'd1};
    vecs[6] = '{1'b1, 16'h0020, 32'h0BAD_F00D, 99, 32'h7777_7777, 32'h0000_0000, 1'b1, 18, 16, 8'd2};

    #3;
    chk("rst_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);
    chk("rst_psel", {31'h0, psel_o}, 32'h0);
    chk("rst_penable", {31'h0, penable_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_err_cnt", {24'h0, error_count_o}, 32'h0);
    chk("rst_paddr", {16'h0, paddr_o}, 32'h0);
    step();
    step();
    reset_n_i = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].wr, vecs[v].addr, vecs[v].wd);
      finish_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].waits, vecs[v].rd, 0,
                  lat, acc, psel_n, pen_n, rdata, err, bad);
      chk($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d_error", v), {31'h0, err}, {31'h0, vecs[v].exp_err});
      chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_access_cycles", v), acc, vecs[v].exp_acc);
      chk($sformatf("v%0d_psel_cycles", v), psel_n, vecs[v].exp_acc + 1);
      chk($sformatf("v%0d_penable_cycles", v), pen_n, vecs[v].exp_acc);
      chk($sformatf("v%0d_err_cnt", v), {24'h0, error_count_o}, {24'h0, vecs[v].exp_cnt});
      chk($sformatf("v%0d_apb_stable", v), bad, 0);
    end

    // Saturation: count is 2 here; 253 more timeouts reach 255, one more holds.
    for (int k = 0; k < 253; k++) begin
      issue(1'b0, 16'h0100, 32'h0);
      finish_xfer(1'b0, 16'h0100, 32'h0, 99, 32'h0, 0, lat, acc, psel_n, pen_n, rdata, err, bad);
    end
    chk("sat_reach_255", {24'h0, error_count_o}, 32'd255);
    issue(1'b0, 16'h0100, 32'h0);
    finish_xfer(1'b0, 16'h0100, 32'h0, 99, 32'h0, 0, lat, acc, psel_n, pen_n, rdata, err, bad);
    chk("sat_hold_255", {24'h0, error_count_o}, 32'd255);
    chk("sat_error", {31'h0, err}, 32'h1);

    // Response back-pressure with a pending command, then next SETUP timing.
    issue(1'b0, 16'h0030, 32'h0);
    finish_xfer(1'b0, 16'h0030, 32'h0, 0, 32'h0BEE_F000, 5, lat, acc, psel_n, pen_n, rdata, err, bad);
    chk("stall_stable", bad, 0);
    chk("stall_rdata", rdata, 32'h0BEE_F000);
    chk("stall_idle_after_hs", {30'h0, cmd_ready_o, psel_o}, 32'h2);
    step();
    cmd_valid_i = 1'b0;
    chk("stall_next_setup", {30'h0, psel_o, penable_o}, 32'h2);
    chk("stall_next_addr", {16'h0, paddr_o}, 32'h0044);
    finish_xfer(1'b1, 16'h0044, 32'h0000_0055, 0, 32'hFFFF_FFFF, 0,
                lat, acc, psel_n, pen_n, rdata, err, bad);
    chk("stall_next_latency", lat, 3);
    chk("stall_next_rdata", rdata, 32'h0);

    // Asynchronous reset in the middle of ACCESS.
    issue(1'b0, 16'h0050, 32'h0);
    begin : wait_access
      int n;
      n = 0;
      while (!penable_o && n < 10) begin
        step();
        n++;
      end
    end
    chk("rst_mid_in_access", {31'h0, penable_o}, 32'h1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("rst_mid_psel", {31'h0, psel_o}, 32'h0);
    chk("rst_mid_penable", {31'h0, penable_o}, 32'h0);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_mid_err_cnt", {24'h0, error_count_o}, 32'h0);
    step();
    reset_n_i = 1'b1;
    step();
    chk("rst_mid_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);
    chk("rst_mid_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
    issue(1'b0, 16'h000C, 32'h0);
    finish_xfer(1'b0, 16'h000C, 32'h0, 1, 32'h0000_0400, 0, lat, acc, psel_n, pen_n, rdata, err, bad);
    chk("post_rst_rdata", rdata, 32'h0000_0400);
    chk("post_rst_error", {31'h0, err}, 32'h0);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_stable", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
